// File: rtl/hex_seq_player.sv
`default_nettype none
// ============================================================================
// hex_seq_player : programmable digit-sequence player with run-time table writes
// Revision 1.0
// ============================================================================
module hex_seq_player #(
  parameter int                     DW    = 4,
  parameter int                     DEPTH = 16,
  parameter logic [DEPTH*DW-1:0]    SEQ   = 64'h0000_3963_2004_4018,
  parameter int                     AW    = $clog2(DEPTH),
  parameter int                     LW    = $clog2(DEPTH + 1)
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iStart,
  input  logic          iEn,
  input  logic [LW-1:0] iLen,
  input  logic          iDir,
  input  logic          iMode,
  input  logic          iWrEn,
  input  logic [AW-1:0] iWrAddr,
  input  logic [DW-1:0] iWrData,
  output logic [DW-1:0] oNum,
  output logic [AW-1:0] oIdx,
  output logic          oValid,
  output logic          oWrap,
  output logic          oDone
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] c_top     = AW'(DEPTH - 1);
  localparam logic [LW-1:0] c_depth_l = LW'(DEPTH);
  localparam logic [AW:0]   c_depth_w = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [DW-1:0] num_q, num_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;
  logic [AW-1:0] first_q, first_d;
  logic [AW-1:0] last_q, last_d;
  logic          dir_q, dir_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] tbl_q [DEPTH];
  logic [DW-1:0] tbl_d [DEPTH];

  logic [AW-1:0] w_len_top;
  logic [AW-1:0] w_first;
  logic [AW-1:0] w_last;
  logic [AW-1:0] w_step_idx;
  logic          w_wr_ok;

  // A length of 0 or anything beyond the table plays the whole table.
  assign w_len_top  = (iLen == '0 || iLen > c_depth_l) ? c_top : AW'(iLen - 1'b1);
  assign w_first    = iDir ? w_len_top : '0;
  assign w_last     = iDir ? '0 : w_len_top;
  assign w_step_idx = dir_q ? idx_q - 1'b1 : idx_q + 1'b1;

  generate
    if ((1 << AW) == DEPTH) begin : g_full_addr
      assign w_wr_ok = 1'b1;
    end else begin : g_part_addr
      assign w_wr_ok = ({1'b0, iWrAddr} < c_depth_w);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    done_d  = done_q;
    first_d = first_q;
    last_d  = last_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    tbl_d   = tbl_q;

    if (iWrEn && w_wr_ok) begin
      tbl_d[iWrAddr] = iWrData;
    end

    // Reads use tbl_q so a same-cycle write to the stepped-to entry shows old data.
    if (iStart) begin
      state_d = S_RUN;
      first_d = w_first;
      last_d  = w_last;
      dir_d   = iDir;
      mode_d  = iMode;
      idx_d   = w_first;
      num_d   = tbl_q[w_first];
      valid_d = 1'b1;
      done_d  = 1'b0;
    end else if (state_q == S_RUN && iEn) begin
      if (idx_q != last_q) begin
        idx_d = w_step_idx;
        num_d = tbl_q[w_step_idx];
      end else if (!mode_q) begin
        idx_d  = first_q;
        num_d  = tbl_q[first_q];
        wrap_d = 1'b1;
      end else begin
        state_d = S_DONE;
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      first_q <= '0;
      last_q  <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= SEQ[i*DW +: DW];
      end
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      first_q <= first_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

  assign oNum   = num_q;
  assign oIdx   = idx_q;
  assign oValid = valid_q;
  assign oWrap  = wrap_q;
  assign oDone  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_seq_player.sv
`default_nettype none
// ============================================================================
// tb_hex_seq_player : directed self-checking bench for hex_seq_player
// Revision 1.0
// ============================================================================
module tb_hex_seq_player;

  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LW    = 5;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic          i_en;
  logic [LW-1:0] i_len;
  logic          i_dir;
  logic          i_mode;
  logic          i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic [DW-1:0] o_num;
  logic [AW-1:0] o_idx;
  logic          o_valid;
  logic          o_wrap;
  logic          o_done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] exp_seq [16] = '{4'h8, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h2,
                               4'h3, 4'h6, 4'h9, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};

  hex_seq_player u_dut (
    .iClk    (clk),
    .iRst    (rst),
    .iStart  (i_start),
    .iEn     (i_en),
    .iLen    (i_len),
    .iDir    (i_dir),
    .iMode   (i_mode),
    .iWrEn   (i_wr_en),
    .iWrAddr (i_wr_addr),
    .iWrData (i_wr_data),
    .oNum    (o_num),
    .oIdx    (o_idx),
    .oValid  (o_valid),
    .oWrap   (o_wrap),
    .oDone   (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input int num,
                         input int valid, input int wrap, input int done);
    chk({tag, ".idx"},   32'(o_idx),   idx);
    chk({tag, ".num"},   32'(o_num),   num);
    chk({tag, ".valid"}, 32'(o_valid), valid);
    chk({tag, ".wrap"},  32'(o_wrap),  wrap);
    chk({tag, ".done"},  32'(o_done),  done);
  endtask

  task automatic start(input int len, input logic dir, input logic mode, input logic en);
    i_start = 1'b1;
    i_len   = LW'(len);
    i_dir   = dir;
    i_mode  = mode;
    i_en    = en;
    step();
    i_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_en = 1'b1; i_len = '0; i_dir = 1'b0; i_mode = 1'b0;
    i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    step();
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    chk_all("idle_en_ignored", 0, 0, 0, 0, 0);

    // Full table ascending loop; start and enable together must not step.
    start(0, 1'b0, 1'b0, 1'b1);
    chk_all("full_first", 0, 8, 1, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("full_loop.idx",  32'(o_idx),  k % 16);
      chk("full_loop.num",  32'(o_num),  32'(exp_seq[k % 16]));
      chk("full_loop.wrap", 32'(o_wrap), (k == 16) ? 1 : 0);
    end

    // Length 3 descending loop.
    start(3, 1'b1, 1'b0, 1'b1);
    chk_all("desc_first", 2, 0, 1, 0, 0);
    step(); chk_all("desc_1", 1, 1, 1, 0, 0);
    step(); chk_all("desc_0", 0, 8, 1, 0, 0);
    step(); chk_all("desc_wrap", 2, 0, 1, 1, 0);
    step(); chk_all("desc_after_wrap", 1, 1, 1, 0, 0);

    // Enable pattern 0,0,1; then a length change outside start is ignored.
    i_en = 1'b0;
    step(); chk_all("en_off_1", 1, 1, 1, 0, 0);
    step(); chk_all("en_off_2", 1, 1, 1, 0, 0);
    i_en = 1'b1;
    step(); chk_all("en_on", 0, 8, 1, 0, 0);
    i_len = 5'd5; i_dir = 1'b0;
    step(); chk_all("len_change_ignored", 2, 0, 1, 1, 0);

    // One-shot length 4.
    start(4, 1'b0, 1'b1, 1'b1);
    chk_all("os_0", 0, 8, 1, 0, 0);
    step(); chk_all("os_1", 1, 1, 1, 0, 0);
    step(); chk_all("os_2", 2, 0, 1, 0, 0);
    step(); chk_all("os_3", 3, 4, 1, 0, 0);
    step(); chk_all("os_done", 3, 4, 0, 0, 1);
    step(); chk_all("os_done_hold", 3, 4, 0, 0, 1);
    start(4, 1'b0, 1'b1, 1'b0);
    chk_all("os_restart", 0, 8, 1, 0, 0);

    // Length 1: every enabled step wraps (loop) or finishes (one-shot).
    start(1, 1'b0, 1'b0, 1'b0);
    chk_all("l1_first", 0, 8, 1, 0, 0);
    i_en = 1'b1;
    step(); chk_all("l1_wrap_a", 0, 8, 1, 1, 0);
    step(); chk_all("l1_wrap_b", 0, 8, 1, 1, 0);
    start(1, 1'b0, 1'b1, 1'b0);
    chk_all("l1os_first", 0, 8, 1, 0, 0);
    i_en = 1'b1;
    step(); chk_all("l1os_done", 0, 8, 0, 0, 1);

    // Table writes: held digit unaffected, new data seen on next step.
    start(0, 1'b0, 1'b0, 1'b0);
    chk_all("wr_start", 0, 8, 1, 0, 0);
    i_wr_en = 1'b1; i_wr_addr = 4'd1; i_wr_data = 4'hF;
    step(); chk_all("wr_hold", 0, 8, 1, 0, 0);
    i_wr_en = 1'b0; i_en = 1'b1;
    step(); chk_all("wr_new_data", 1, 15, 1, 0, 0);
    start(0, 1'b0, 1'b0, 1'b0);
    chk_all("wr_restart", 0, 8, 1, 0, 0);
    i_en = 1'b1; i_wr_en = 1'b1; i_wr_addr = 4'd1; i_wr_data = 4'h5;
    step(); chk_all("wr_same_cycle_old", 1, 15, 1, 0, 0);
    i_wr_en = 1'b0;
    start(2, 1'b1, 1'b0, 1'b0);
    chk_all("wr_same_cycle_new", 1, 5, 1, 0, 0);

    // Reset mid-run with a colliding write restores the table.
    i_en = 1'b1;
    step(); chk_all("pre_reset", 0, 8, 1, 0, 0);
    rst = 1'b1; i_wr_en = 1'b1; i_wr_addr = 4'd0; i_wr_data = 4'hA;
    step(); chk_all("mid_reset", 0, 0, 0, 0, 0);
    rst = 1'b0; i_wr_en = 1'b0;
    start(0, 1'b0, 1'b0, 1'b1);
    chk_all("post_reset_0", 0, 8, 1, 0, 0);
    step(); chk_all("post_reset_1", 1, 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
